// File: rtl/avl_burst_dpram_slave.sv
// Avalon-MM burst slave in front of a word RAM: pipelined read bursts with a
// fixed two-cycle latency, and streamed write bursts with per-byte enables.
module avl_burst_dpram_slave #(
    parameter int pADDRESS_BITS = 8,
    parameter int pDATA_BITS    = 32,
    parameter int pBURST_BITS   = 5
) (
    input  logic                      iCLK,
    input  logic                      iRESET,
    input  logic                      iCHIPSELECT,
    input  logic [pADDRESS_BITS-1:0]  iADDRESS,
    input  logic                      iREAD,
    input  logic                      iWRITE,
    input  logic [pBURST_BITS-1:0]    iBURST_COUNT,
    input  logic [pDATA_BITS-1:0]     iWRITE_DATA,
    input  logic [pDATA_BITS/8-1:0]   iBYTE_ENABLE,
    output logic [pDATA_BITS-1:0]     oREAD_DATA,
    output logic                      oREAD_DATAVALID,
    output logic                      oWAIT_REQUEST
);

    localparam int DEPTH = 2 ** pADDRESS_BITS;
    localparam int BYTES = pDATA_BITS / 8;

    typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_BURST} state_t;

    state_t                   state_q, state_d;
    logic [pADDRESS_BITS-1:0] addr_q, addr_d;
    logic [pBURST_BITS-1:0]   cnt_q, cnt_d;
    logic                     wait_q, wait_d;
    logic                     issue_q, issue_d;
    logic                     valid_q, valid_d;
    logic [pDATA_BITS-1:0]    rdata_q, rdata_d;

    logic [pDATA_BITS-1:0]    mem [DEPTH];
    logic [pDATA_BITS-1:0]    ram_q;
    logic                     mem_we;
    logic [pADDRESS_BITS-1:0] mem_waddr;

    logic                     accept;
    logic [pBURST_BITS-1:0]   burst_len;

    assign accept    = iCHIPSELECT & (iREAD | iWRITE) & ~wait_q;
    assign burst_len = (iBURST_COUNT == '0) ? pBURST_BITS'(1) : iBURST_COUNT;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wait_d    = 1'b0;
        issue_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        valid_d   = issue_q;
        rdata_d   = issue_q ? ram_q : rdata_q;

        unique case (state_q)
            IDLE: begin
                // Leaving READ_BURST lands here with wait_q still high for the
                // final read-pipeline cycle; accept is blocked until it clears.
                if (accept) begin
                    addr_d = iADDRESS;
                    if (iWRITE) begin
                        mem_we    = 1'b1;
                        mem_waddr = iADDRESS;
                        cnt_d     = burst_len - 1'b1;
                        if (burst_len != pBURST_BITS'(1)) state_d = WRITE_BURST;
                    end else begin
                        cnt_d   = burst_len;
                        wait_d  = 1'b1;
                        state_d = READ_BURST;
                    end
                end
            end
            WRITE_BURST: begin
                if (iCHIPSELECT && iWRITE) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_q + 1'b1;
                    addr_d    = addr_q + 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == pBURST_BITS'(1)) state_d = IDLE;
                end
            end
            READ_BURST: begin
                wait_d  = 1'b1;
                issue_d = 1'b1;
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == pBURST_BITS'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            issue_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            issue_q <= issue_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is not reset; the read port samples every cycle and only issue_q
    // decides whether the word is forwarded.
    always_ff @(posedge iCLK) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (iBYTE_ENABLE[b]) mem[mem_waddr][8*b +: 8] <= iWRITE_DATA[8*b +: 8];
            end
        end
        ram_q <= mem[addr_q];
    end

    assign oREAD_DATA      = rdata_q;
    assign oREAD_DATAVALID = valid_q;
    assign oWAIT_REQUEST   = wait_q;

endmodule

// File: tb/tb_avl_burst_dpram_slave.sv
// Directed bench for avl_burst_dpram_slave: burst writes/reads, wrap, byte
// enables, back-to-back reads, read/write collision and mid-burst reset.
module tb_avl_burst_dpram_slave;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [7:0]  addr;
    logic        rd;
    logic        wr;
    logic [4:0]  bc;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        rvalid;
    logic        waitreq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rbuf [16];
    int          rgot;

    avl_burst_dpram_slave #(
        .pADDRESS_BITS(8),
        .pDATA_BITS   (32),
        .pBURST_BITS  (5)
    ) dut (
        .iCLK           (clk),
        .iRESET         (rst),
        .iCHIPSELECT    (cs),
        .iADDRESS       (addr),
        .iREAD          (rd),
        .iWRITE         (wr),
        .iBURST_COUNT   (bc),
        .iWRITE_DATA    (wdata),
        .iBYTE_ENABLE   (be),
        .oREAD_DATA     (rdata),
        .oREAD_DATAVALID(rvalid),
        .oWAIT_REQUEST  (waitreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic [4:0] n);
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        be    = b;
        bc    = n;
        tick();
        wr    = 1'b0;
    endtask

    // Issues one read burst, collects the returned words into rbuf and checks
    // latency, contiguity and the waitrequest window.
    task automatic do_read(input string tag, input logic [7:0] a, input logic [4:0] n);
        int nn;
        int first_t;
        int last_t;
        int wait_hi;
        logic wait_at_last;
        nn      = (n == 5'd0) ? 1 : int'(n);
        first_t = -1;
        last_t  = -1;
        wait_at_last = 1'b1;
        rgot    = 0;
        cs   = 1'b1;
        rd   = 1'b1;
        addr = a;
        bc   = n;
        tick();
        rd   = 1'b0;
        wait_hi = waitreq ? 1 : 0;
        for (int t = 1; t <= nn + 2; t++) begin
            tick();
            if (waitreq) wait_hi++;
            if (rvalid) begin
                if (first_t < 0) first_t = t;
                last_t = t;
                wait_at_last = waitreq;
                if (rgot < 16) rbuf[rgot] = rdata;
                rgot++;
            end
        end
        check({tag, "_count"},   32'(rgot),    32'(nn));
        check({tag, "_first"},   32'(first_t), 32'd2);
        check({tag, "_last"},    32'(last_t),  32'(nn + 1));
        check({tag, "_waithi"},  32'(wait_hi), 32'(nn + 1));
        check({tag, "_waitlast"}, 32'(wait_at_last), 32'd0);
    endtask

    initial begin
        int vcount;
        int acc_t;
        logic low_seen;
        logic low_valid;
        logic will_acc;

        rst = 1'b1; cs = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
        bc = '0; wdata = '0; be = '0;
        #12;
        check("rst_rdata", rdata, 32'h0);
        check("rst_valid", 32'(rvalid), 32'd0);
        check("rst_wait",  32'(waitreq), 32'd0);
        rst = 1'b0;
        tick();

        // single write then read
        write_beat(8'h10, 32'hDEADBEEF, 4'hF, 5'd1);
        check("wr1_wait", 32'(waitreq), 32'd0);
        do_read("rd1", 8'h10, 5'd1);
        check("rd1_data", rbuf[0], 32'hDEADBEEF);

        // write burst with a two-cycle gap between beats 2 and 3
        write_beat(8'h20, 32'd1, 4'hF, 5'd4);
        write_beat(8'h99, 32'd2, 4'hF, 5'd9);
        tick();
        tick();
        write_beat(8'h99, 32'd3, 4'hF, 5'd9);
        write_beat(8'h99, 32'd4, 4'hF, 5'd9);
        do_read("rd4", 8'h20, 5'd4);
        for (int i = 0; i < 4; i++) check("rd4_data", rbuf[i], 32'(i + 1));

        // address wrap
        write_beat(8'hFE, 32'h0000000A, 4'hF, 5'd3);
        write_beat(8'h00, 32'h0000000B, 4'hF, 5'd3);
        write_beat(8'h00, 32'h0000000C, 4'hF, 5'd3);
        do_read("rdwrap", 8'hFE, 5'd3);
        check("wrap0", rbuf[0], 32'h0000000A);
        check("wrap1", rbuf[1], 32'h0000000B);
        check("wrap2", rbuf[2], 32'h0000000C);
        do_read("rd00", 8'h00, 5'd1);
        check("wrap_ram0", rbuf[0], 32'h0000000C);

        // byte enables and burstcount 0
        write_beat(8'h30, 32'h11223344, 4'hF, 5'd1);
        write_beat(8'h30, 32'hAABBCCDD, 4'b0101, 5'd0);
        write_beat(8'h31, 32'h31313131, 4'hF, 5'd1);
        do_read("rdbe", 8'h30, 5'd0);
        check("be_data", rbuf[0], 32'h11BB33DD);
        do_read("rd31", 8'h31, 5'd1);
        check("bc0_next", rbuf[0], 32'h31313131);

        // back-to-back reads: second held off until the last-data cycle
        write_beat(8'h40, 32'h40000000, 4'hF, 5'd2);
        write_beat(8'h00, 32'h40000001, 4'hF, 5'd2);
        write_beat(8'h50, 32'h50000000, 4'hF, 5'd2);
        write_beat(8'h00, 32'h50000001, 4'hF, 5'd2);
        cs = 1'b1; rd = 1'b1; addr = 8'h40; bc = 5'd2;
        tick();
        addr = 8'h50;
        acc_t = -1; rgot = 0; low_seen = 1'b0; low_valid = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            will_acc = rd && !waitreq;
            tick();
            if (will_acc) begin
                acc_t = t;
                rd = 1'b0;
            end
            if (!waitreq && !low_seen) begin
                low_seen  = 1'b1;
                low_valid = rvalid;
            end
            if (rvalid) begin
                if (rgot < 16) rbuf[rgot] = rdata;
                rgot++;
            end
        end
        rd = 1'b0;
        check("b2b_acc", 32'(acc_t), 32'd4);
        check("b2b_lowvalid", 32'(low_valid), 32'd1);
        check("b2b_count", 32'(rgot), 32'd4);
        check("b2b_d0", rbuf[0], 32'h40000000);
        check("b2b_d1", rbuf[1], 32'h40000001);
        check("b2b_d2", rbuf[2], 32'h50000000);
        check("b2b_d3", rbuf[3], 32'h50000001);

        // read and write together in IDLE: write wins
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 8'h60; wdata = 32'h66666666; be = 4'hF; bc = 5'd1;
        tick();
        wr = 1'b0; rd = 1'b0;
        vcount = 0;
        for (int t = 0; t < 4; t++) begin
            if (rvalid) vcount++;
            tick();
        end
        check("rw_novalid", 32'(vcount), 32'd0);
        do_read("rdrw", 8'h60, 5'd1);
        check("rw_data", rbuf[0], 32'h66666666);

        // reset during beat 3 of a 16-word read
        cs = 1'b1; rd = 1'b1; addr = 8'h20; bc = 5'd16;
        tick();
        rd = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("rst_beat3_valid", 32'(rvalid), 32'd1);
        check("rst_beat3_data", rdata, 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rvalid), 32'd0);
        check("mid_rst_wait",  32'(waitreq), 32'd0);
        check("mid_rst_rdata", rdata, 32'h0);
        tick();
        rst = 1'b0;
        vcount = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (rvalid) vcount++;
        end
        check("post_rst_quiet", 32'(vcount), 32'd0);
        do_read("rdpost", 8'h30, 5'd1);
        check("post_rst_data", rbuf[0], 32'h11BB33DD);
        do_read("rdpost4", 8'h20, 5'd4);
        for (int i = 0; i < 4; i++) check("post_rst_burst", rbuf[i], 32'(i + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avl_burst_dpram_slave.md
Name: avl_burst_dpram_slave

Overview:
- Avalon-MM burst responder.
- Terminates the JTAG/bridge Avalon master (address, read, write, burstcount, waitrequest, readdatavalid) into an internal dual-purpose word RAM.
- Sits behind the top-level chip-select decode (DPRAM_CS) and returns read data to the master's read-data mux.
- Supports fixed-latency pipelined read bursts and streamed write bursts with byte enables.

Parameters:
- pADDRESS_BITS, 8, word-address width; RAM depth = 2**pADDRESS_BITS words.
- pDATA_BITS, 32, data word width; must be a multiple of 8.
- pBURST_BITS, 5, burstcount width; maximum burst = 2**(pBURST_BITS-1) = 16.

Ports:
- iCLK  in  1  system clock; all logic rising-edge.
- iRESET  in  1  asynchronous, active-high reset.
- iCHIPSELECT  in  1  slave selected; iREAD/iWRITE ignored when low.
- iADDRESS  in  pADDRESS_BITS  word address, sampled on burst start only.
- iREAD  in  1  read request.
- iWRITE  in  1  write request / write beat.
- iBURST_COUNT  in  pBURST_BITS  burst length in words, sampled on burst start.
- iWRITE_DATA  in  pDATA_BITS  write data per beat.
- iBYTE_ENABLE  in  pDATA_BITS/8  per-byte write enable.
- oREAD_DATA  out  pDATA_BITS  read data.
- oREAD_DATAVALID  out  1  oREAD_DATA valid this cycle.
- oWAIT_REQUEST  out  1  slave cannot accept a command this cycle.

Behaviour:
- Clocking/reset: one clock (iCLK); reset is asynchronous and active-high (iRESET).
- Reset values: oREAD_DATA=0, oREAD_DATAVALID=0, oWAIT_REQUEST=0, state=IDLE, counters=0. RAM contents are not reset.
- Accept: a command is accepted on an edge where iCHIPSELECT=1, (iREAD|iWRITE)=1 and oWAIT_REQUEST=0.
- Burstcount: 0 is treated as 1. Values above 16 are not clipped; the counter runs the full sampled value.
- States: IDLE, WRITE_BURST, READ_BURST.
- IDLE:
  - Write accept: write beat 0 to iADDRESS, load the remaining count = N-1. Go to WRITE_BURST if N>1, else stay in IDLE.
  - Read accept: load address and N, set oWAIT_REQUEST=1 on the next cycle, go to READ_BURST.
  - iREAD and iWRITE both high: write wins and the read is dropped.
- WRITE_BURST:
  - oWAIT_REQUEST=0.
  - Each cycle with iWRITE=1 is one beat: write at address+1 (wrapping modulo depth) and decrement the count. iADDRESS and iBURST_COUNT are ignored.
  - iWRITE=0 inserts an idle cycle; no beat and no timeout.
  - After the last beat, return to IDLE.
  - iREAD is ignored in this state.
- Byte enables: a byte lane is written only when its iBYTE_ENABLE bit is 1. Lanes with the bit clear keep their old value.
- READ_BURST:
  - One RAM read is issued per cycle starting the cycle after accept. The RAM read is registered and the output is registered.
  - Accept at edge k → oREAD_DATAVALID high after edge k+2 for exactly N consecutive cycles, with no gaps.
  - Address increments per word and wraps from 2**pADDRESS_BITS-1 to 0.
  - oWAIT_REQUEST stays 1 from the cycle after accept until the cycle carrying the last valid word. It is 0 in that cycle, so a new command can be accepted there.
- Read-after-write: a read accepted the cycle after a write beat returns the newly written data; there is no bypass hazard because the RAM write completes at that edge.
- oREAD_DATA holds its last value when oREAD_DATAVALID=0.
- Reset mid-burst: the burst is abandoned immediately and oREAD_DATAVALID drops asynchronously. Words already written stay in RAM; remaining beats are not written.
- iCHIPSELECT low mid-burst: write beats are not counted while it is low; in-flight read data still returns.

Test Plan:
- Single write then read: write 0xDEADBEEF at 0x10 with byte enable 0xF and burst 1, then read burst 1 at 0x10 → one oREAD_DATAVALID pulse with 0xDEADBEEF exactly 2 cycles after accept; oWAIT_REQUEST high for 2 cycles.
- Write burst with gaps: burst 4 at 0x20 with data 1,2,3,4 and iWRITE deasserted for 2 cycles between beats 2 and 3 → read burst 4 at 0x20 returns 1,2,3,4 on 4 consecutive valid cycles.
- Wrap-around: write burst 3 at 0xFE with data A,B,C → RAM[0xFE]=A, RAM[0xFF]=B, RAM[0x00]=C; read burst 3 at 0xFE returns A,B,C.
- Byte enables and burstcount 0: RAM[0x30]=0x11223344, then write 0xAABBCCDD with byte enable 0b0101 and burstcount 0 → read gives 0x11BB33DD; burstcount 0 behaves as 1.
- Back-to-back and simultaneous requests:
  - Two read bursts of 2, the second issued while waitrequest is high → the second is held off and accepted in the last-data cycle; 4 valid cycles back-to-back.
  - iREAD=iWRITE=1 in IDLE → write performed, no oREAD_DATAVALID.
- Reset mid read burst: assert iRESET during beat 3 of a 16-word read → oREAD_DATAVALID and oWAIT_REQUEST go 0 immediately; after release, a new read of burst 1 completes normally and earlier-written RAM data is intact.
